// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU.
// One quotient bit per clock. The result is packed as {remainder, quotient}
// and is held for as long as the controller keeps start high.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div,
    input  logic [WIDTH-1:0]     opdata1,
    input  logic [WIDTH-1:0]     opdata2,
    input  logic                 start,
    input  logic                 annul,
    output logic [2*WIDTH-1:0]   result,
    output logic                 ready
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

    state_t state, next_state;

    // Latched operand magnitudes and sign-correction flags
    logic [WIDTH-1:0] dividend_abs;
    logic [WIDTH-1:0] divisor_abs;
    logic             neg_quot;
    logic             neg_rem;

    // Working register: {partial remainder, remaining dividend / quotient bits}
    logic [2*WIDTH:0] wr;
    logic [CW-1:0]    count;

    // Combinational helpers
    logic             op1_neg, op2_neg;
    logic [WIDTH-1:0] op1_abs, op2_abs;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] rem_raw, quot_raw;
    logic [WIDTH-1:0] rem_fix, quot_fix;
    logic [2*WIDTH:0] wr_step;
    logic             last_iter;
    logic             accept;

    logic [2*WIDTH-1:0] result_d;
    logic               ready_d;

    // Operand magnitudes and one restoring iteration
    always_comb begin
        op1_neg  = signed_div & opdata1[WIDTH-1];
        op2_neg  = signed_div & opdata2[WIDTH-1];
        op1_abs  = op1_neg ? -opdata1 : opdata1;
        op2_abs  = op2_neg ? -opdata2 : opdata2;

        // Trial subtract; diff[WIDTH] set means the partial remainder was smaller.
        diff     = wr[2*WIDTH:WIDTH] - {1'b0, divisor_abs};
        // Post-shift remainder is either the old upper part or the difference;
        // the new quotient bit enters at bit 0.
        rem_raw  = diff[WIDTH] ? wr[2*WIDTH-1:WIDTH] : diff[WIDTH-1:0];
        quot_raw = {wr[WIDTH-2:0], ~diff[WIDTH]};
        wr_step  = {rem_raw, wr[WIDTH-1], quot_raw};

        quot_fix = neg_quot ? -quot_raw : quot_raw;
        rem_fix  = neg_rem  ? -rem_raw  : rem_raw;

        last_iter = (count == LAST_ITER);
        accept    = start & ~annul;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= FREE;
        else     state <= next_state;
    end

    // Next-state decode
    always_comb begin
        next_state = state;
        unique case (state)
            FREE: begin
                if (accept) next_state = (opdata2 == '0) ? BYZERO : ON;
            end
            BYZERO: next_state = annul ? FREE : END;
            ON: begin
                if (annul)          next_state = FREE;
                else if (last_iter) next_state = END;
            end
            END: begin
                // annul is deliberately ignored once the result is presented
                if (!start) next_state = FREE;
            end
            default: next_state = FREE;
        endcase
    end

    // Output decode: next values for the registered result/ready
    always_comb begin
        result_d = result;
        ready_d  = ready;
        unique case (state)
            FREE: begin
                result_d = '0;
                ready_d  = 1'b0;
            end
            BYZERO: begin
                // Divide by zero is defined to return 0 with no trap
                result_d = '0;
                ready_d  = ~annul;
            end
            ON: begin
                if (annul) begin
                    result_d = '0;
                    ready_d  = 1'b0;
                end else if (last_iter) begin
                    // Sign correction is folded into the final iteration edge
                    result_d = {rem_fix, quot_fix};
                    ready_d  = 1'b1;
                end
            end
            END: begin
                if (!start) begin
                    result_d = '0;
                    ready_d  = 1'b0;
                end
            end
            default: begin
                result_d = '0;
                ready_d  = 1'b0;
            end
        endcase
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
            ready  <= 1'b0;
        end else begin
            result <= result_d;
            ready  <= ready_d;
        end
    end

    // Operand capture, iteration datapath and iteration counter
    always_ff @(posedge clk) begin
        if (rst) begin
            dividend_abs <= '0;
            divisor_abs  <= '0;
            neg_quot     <= 1'b0;
            neg_rem      <= 1'b0;
            wr           <= '0;
            count        <= '0;
        end else begin
            unique case (state)
                FREE: begin
                    if (accept && opdata2 != '0) begin
                        dividend_abs <= op1_abs;
                        divisor_abs  <= op2_abs;
                        neg_quot     <= op1_neg ^ op2_neg;
                        neg_rem      <= op1_neg;
                        wr           <= {{WIDTH{1'b0}}, op1_abs, 1'b0};
                        count        <= '0;
                    end
                end
                ON: begin
                    if (!annul) begin
                        wr    <= wr_step;
                        count <= count + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit with directed vectors.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div;
    logic [31:0] opdata1, opdata2;
    logic        start, annul;
    logic [63:0] result;
    logic        ready;

    div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .signed_div(signed_div),
        .opdata1(opdata1), .opdata2(opdata2),
        .start(start), .annul(annul),
        .result(result), .ready(ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        int          lat;
        int          t0;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;
    logic ready_q = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every rising ready must match the oldest expected result and latency
    always @(negedge clk) begin
        if (ready && !ready_q) begin
            if (sb.size() == 0) begin
                chk("unexpected_ready", 64'(ready), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", result, e.res);
                chk("latency", 64'(cyc - e.t0 + 1), 64'(e.lat));
            end
        end
        ready_q <= ready;
    end

    // Issue one divide, hold start for 'hold' cycles after ready, then release
    task automatic do_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int lat, input int hold);
        exp_t e;
        int   waited;
        @(negedge clk);
        signed_div = sg; opdata1 = a; opdata2 = b; start = 1'b1;
        e.res = exp; e.lat = lat; e.t0 = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        // operands must have been captured; scramble them
        signed_div = ~sg; opdata1 = 32'hA5A5_5A5A; opdata2 = 32'h0000_0003;
        waited = 0;
        while (!ready && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        if (!ready) chk("ready_timeout", 64'(ready), 64'd1);
        repeat (hold) begin
            @(negedge clk);
            chk("hold_ready", 64'(ready), 64'd1);
            chk("hold_result", result, exp);
        end
        start = 1'b0;
        @(negedge clk);
        chk("release_ready", 64'(ready), 64'd0);
        chk("release_result", result, 64'd0);
    endtask

    initial begin
        rst = 1'b1; signed_div = 1'b0; opdata1 = '0; opdata2 = '0;
        start = 1'b0; annul = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ready", 64'(ready), 64'd0);
        chk("reset_result", result, 64'd0);
        rst = 1'b0;

        do_div(1'b0, 32'd100,       32'd7,       64'h00000002_0000000E, 33, 5);
        do_div(1'b1, 32'hFFFFFFF9, 32'h2,        64'hFFFFFFFF_FFFFFFFD, 33, 1);
        do_div(1'b0, 32'hFFFFFFF9, 32'h2,        64'h00000001_7FFFFFFC, 33, 1);
        do_div(1'b1, 32'd5,         32'd0,       64'h0,                  2, 3);
        do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33, 1);
        do_div(1'b1, 32'd7,         32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33, 1);
        do_div(1'b1, 32'hFFFFFFF8, 32'hFFFFFFFE, 64'h00000000_00000004, 33, 1);
        do_div(1'b0, 32'd5,         32'hFFFFFFFF, 64'h00000005_00000000, 33, 1);
        do_div(1'b0, 32'hFFFFFFFF, 32'd1,        64'h00000000_FFFFFFFF, 33, 1);

        // Annul at iteration 10: no result ever appears
        @(negedge clk);
        signed_div = 1'b0; opdata1 = 32'd1000; opdata2 = 32'd3; start = 1'b1;
        repeat (10) @(negedge clk);
        annul = 1'b1;
        @(negedge clk);
        annul = 1'b0; start = 1'b0;
        chk("annul_ready", 64'(ready), 64'd0);
        chk("annul_result", result, 64'd0);
        repeat (40) @(negedge clk);
        chk("annul_no_ready", 64'(ready), 64'd0);
        do_div(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33, 1);

        // start dropped mid-operation: still completes, then leaves END
        begin
            exp_t e;
            int   waited;
            @(negedge clk);
            signed_div = 1'b0; opdata1 = 32'd50; opdata2 = 32'd8; start = 1'b1;
            e.res = 64'h00000002_00000006; e.lat = 33; e.t0 = cyc + 1;
            sb.push_back(e);
            repeat (5) @(negedge clk);
            start = 1'b0;
            waited = 0;
            while (!ready && waited < 60) begin
                @(negedge clk);
                waited++;
            end
            if (!ready) chk("drop_timeout", 64'(ready), 64'd1);
            @(negedge clk);
            chk("drop_exit_ready", 64'(ready), 64'd0);
            chk("drop_exit_result", result, 64'd0);
        end

        // Reset mid-operation
        @(negedge clk);
        signed_div = 1'b1; opdata1 = 32'hFFFFFF00; opdata2 = 32'd7; start = 1'b1;
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ready", 64'(ready), 64'd0);
        chk("midrst_result", result, 64'd0);
        rst = 1'b0; start = 1'b0;
        repeat (40) @(negedge clk);
        chk("midrst_no_ready", 64'(ready), 64'd0);

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, checks);
        $fatal(1);
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider for DIV/DIVU in the execute stage.
- Sits directly upstream of the ALU and produces the 64-bit divide result that the ALU writes to HI/LO for the DIV/DIVU ops.
- The pipeline controller holds start high and stalls the pipeline until ready is asserted.
- Packing: remainder in [63:32] (HI), quotient in [31:0] (LO).

Parameters:
- WIDTH, 32, operand width; iteration count equals WIDTH. Only 32 is supported.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- signed_div  in  1  1 = DIV (two's-complement operands), 0 = DIVU
- opdata1  in  32  dividend (rs)
- opdata2  in  32  divisor (rt)
- start  in  1  level request; held high by the controller until ready is seen
- annul  in  1  abort the current operation (exception or flush)
- result  out  64  {remainder, quotient}; valid only while ready = 1
- ready  out  1  result valid; registered

Behaviour:
- Reset: when rst = 1 at an edge, state goes to FREE, ready = 0, result = 0, count = 0. This applies in any state, mid-operation included.
- All outputs are registered. result and ready change only on clock edges.
- States: FREE, BYZERO, ON, END.
- FREE:
  - start = 1 and annul = 0 and opdata2 = 0: go to BYZERO.
  - start = 1 and annul = 0 and opdata2 != 0: go to ON. At the same edge, latch the operands, latch signed_div, clear count, and load the working register.
  - start = 0 or annul = 1: stay in FREE.
- Operand latching (FREE -> ON):
  - If signed_div = 1 and an operand is negative, latch its two's-complement magnitude.
  - Also latch the sign of the dividend and the XOR of the operand signs, for use in correction.
  - Inputs are don't-care after this edge.
- Working register (WIDTH*2+1 bits): initialised to {WIDTH'b0, |dividend|, 1'b0}.
- ON, one iteration per edge:
  - diff = upper WIDTH+1 bits minus {1'b0, |divisor|}.
  - diff negative: shift the working register left by 1, appending 0.
  - Otherwise: replace the upper part with diff, then shift left, appending 1.
  - count increments on each iteration.
  - After the 32nd iteration (count reaches 32), go to END.
- BYZERO: go to END with a raw result of 0 on the next edge. No trap is raised; MIPS leaves the result undefined and we define it as 0.
- Entering END, sign correction is applied:
  - If signed and the operand signs differ, negate the quotient.
  - If signed and the dividend was negative, negate the remainder.
  - The corrected value is registered into result, and ready becomes 1.
- END:
  - While start = 1: stay in END, hold result, ready = 1.
  - When start = 0: go to FREE. At that edge ready = 0 and result = 0.
  - annul is ignored in END.
- Latency:
  - Non-zero divisor: ready is high in the cycle after the 33rd rising edge, counting the edge that samples start = 1 in FREE as edge 1.
  - Zero divisor: ready is high after 2 edges.
- Annul in ON or BYZERO: go to FREE at the next edge; ready stays 0 and result = 0.
- Edge cases:
  - start dropped mid-ON (illegal controller behaviour): the operation continues to END, then exits to FREE on the next edge.
  - 0x80000000 / 0xFFFFFFFF signed: quotient = 0x80000000, remainder = 0. No overflow flag.
  - Back-to-back divides: a new divide needs at least one FREE cycle between operations. A new operation cannot start in END.

Test Plan:
- Unsigned divide:
  - Stimulus: DIVU 100 / 7, start held.
  - Required: ready rises after exactly 33 edges; result = 0x00000002_0000000E; held for as long as start stays high.
- Signed sign correction:
  - Stimulus: DIV -7 / 2, i.e. 0xFFFFFFF9 / 0x00000002.
  - Required: result = 0xFFFFFFFF_FFFFFFFD.
  - Repeat with DIVU on the same operands. Required: quotient = 0x7FFFFFFC, remainder = 0x00000001.
- Divide by zero:
  - Stimulus: DIV 5 / 0.
  - Required: ready after 2 edges; result = 0. Drop start: ready = 0 on the next edge.
- Annul:
  - Stimulus: assert annul for 1 cycle at iteration 10.
  - Required: FREE at the next edge; ready never asserts; result = 0. A following DIVU 9 / 3 returns 0x00000000_00000003 with full latency.
- Signed corner and reset:
  - Stimulus: DIV 0x80000000 / 0xFFFFFFFF.
  - Required: result = 0x00000000_80000000.
  - Stimulus: assert rst mid-ON.
  - Required: next edge state = FREE, ready = 0, result = 0; no stale ready later.
